// File: rtl/pc_fetch_ctrl.sv
// Fetch-address generator for a word-indexed instruction ROM: reset/start sequencing, stall hold, redirects.
// Optional macro FETCH_BOUND_CHECK_EN traps out-of-range fetch addresses into a sticky FAULT state.
module pc_fetch_ctrl #(
    parameter logic [31:0] RST_ADDR  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 1,
    parameter int unsigned ROM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    output logic [31:0] pc_addr_o_ROM,
    output logic        chip_enable_o_ROM,
    output logic        fetch_valid_o,
    output logic        fetch_fault_o
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_RESET,
        S_START,
        S_RUN,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        ce_q;
    logic        fault_q;

    logic [31:0] pc_d;
    logic        load_d;
    logic        oob_d;
    logic        active_d;

    assign active_d = (state_q == S_RUN) || (state_q == S_HOLD);
    // A redirect always loads, even under stall; the loaded PC then simply waits in HOLD.
    assign load_d   = redirect_valid_i || !stall_i;
    assign pc_d     = redirect_valid_i ? redirect_addr_i : (pc_q + PC_STEP);
    assign oob_d    = BOUND_CHECK && (pc_d >= ROM_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= RST_ADDR;
            ce_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: state_q <= S_START;
                S_START: begin
                    state_q <= S_RUN;
                    ce_q    <= 1'b1;
                end
                S_RUN, S_HOLD: begin
                    if (load_d) begin
                        if (oob_d) begin
                            // PC stays at the last in-range value for post-mortem inspection.
                            state_q <= S_FAULT;
                            ce_q    <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            pc_q    <= pc_d;
                        end
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_FAULT: state_q <= S_FAULT;
                default: begin
                    state_q <= S_RESET;
                    pc_q    <= RST_ADDR;
                    ce_q    <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_addr_o_ROM     = pc_q;
    assign chip_enable_o_ROM = ce_q;
    assign fetch_fault_o     = BOUND_CHECK ? fault_q : 1'b0;
    assign fetch_valid_o     = ce_q && active_d && !stall_i && !redirect_valid_i;

endmodule
